// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory arbiter.
// Contents:
//   arb_state_t               - arbiter sequencing states
//   ARB_OWN_IF / ARB_OWN_D    - encoding of the current access owner
//   CPU_ADDR_W / CPU_DATA_W   - default bus widths
//   ARB_MAX_D_STREAK / ARB_TIMEOUT - default arbitration and watchdog settings
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic ARB_OWN_IF = 1'b0;
    localparam logic ARB_OWN_D  = 1'b1;

    localparam int CPU_ADDR_W       = 32;
    localparam int CPU_DATA_W       = 32;
    localparam int ARB_MAX_D_STREAK = 4;
    localparam int ARB_TIMEOUT      = 15;

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog for the memory arbiter.
// A loadable down-counter. The arbiter loads it on every grant and lets it
// run while an access is outstanding; expired is raised in the BUSY cycle
// numbered TIMEOUT (counting the first BUSY cycle as 1).
// Ports:
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset
//   load    in  reload the counter for a new access
//   run     in  access outstanding (decrement enable, qualifies expired)
//   expired out watchdog reached its terminal count
module arb_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Loading TIMEOUT-1 makes the terminal count coincide with the
    // TIMEOUT-th BUSY cycle, since the first BUSY cycle sees the loaded value.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 8'(TIMEOUT - 1);
        end else if (run && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == 8'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Requests are sampled only in IDLE; the winner's address, store data and
// direction are latched and drive the memory from registers during BUSY.
// Completion (mem_rdy or watchdog abort) produces a one-cycle rdy pulse to
// the owner in RESP. Every output is a flop, so there is no input-to-output
// combinational path, and async reset drops the strobes immediately.
// Ports:
//   clk, rst                          clock, async active-low reset
//   if_req/if_addr                    fetch request and address
//   if_rdy/if_err/if_rdata            fetch completion pulse, abort flag, data
//   d_req/d_we/d_addr/d_wdata         data request, store flag, address, data
//   d_rdy/d_err/d_rdata               data completion pulse, abort flag, data
//   mem_re/mem_we/mem_addr/mem_wdata  memory strobes, address, write data
//   mem_rdata/mem_rdy                 memory read data and completion
//
// state | meaning
// IDLE  | sample requests, pick winner, latch access
// BUSY  | strobe held, wait for mem_rdy or watchdog expiry
// RESP  | one-cycle rdy/err pulse to owner, strobes low
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = CPU_ADDR_W,
    parameter int DATA_W       = CPU_DATA_W,
    parameter int MAX_D_STREAK = ARB_MAX_D_STREAK,
    parameter int TIMEOUT      = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rdy,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              if_rdy_q, if_rdy_d;
    logic              if_err_q, if_err_d;
    logic              d_rdy_q, d_rdy_d;
    logic              d_err_q, d_err_d;

    logic              fetch_wins;
    logic              wd_load;
    logic              wd_run;
    logic              wd_expired;

    assign wd_run = (state_q == BUSY);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst),
        .load    (wd_load),
        .run     (wd_run),
        .expired (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        re_d       = re_q;
        we_d       = we_q;
        if_rdy_d   = 1'b0;
        if_err_d   = 1'b0;
        d_rdy_d    = 1'b0;
        d_err_d    = 1'b0;
        wd_load    = 1'b0;

        // Data wins by default; a waiting fetch is forced through once the
        // data port has had MAX_D_STREAK grants in a row.
        fetch_wins = if_req && (!d_req || (streak_q == STREAK_MAX));

        unique case (state_q)
            IDLE: begin
                if (fetch_wins) begin
                    state_d  = BUSY;
                    owner_d  = ARB_OWN_IF;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    re_d     = 1'b1;
                    we_d     = 1'b0;
                    streak_d = '0;
                    wd_load  = 1'b1;
                end else if (d_req) begin
                    state_d = BUSY;
                    owner_d = ARB_OWN_D;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    re_d    = !d_we;
                    we_d    = d_we;
                    wd_load = 1'b1;
                    if (if_req) begin
                        if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        streak_d = '0;
                    end
                end else if (!if_req) begin
                    streak_d = '0;
                end
            end

            BUSY: begin
                // mem_rdy takes precedence over a same-cycle watchdog expiry.
                if (mem_rdy || wd_expired) begin
                    state_d = RESP;
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    if (owner_q == ARB_OWN_IF) begin
                        if_rdy_d = 1'b1;
                        if_err_d = !mem_rdy;
                        if (mem_rdy) begin
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_rdy_d = 1'b1;
                        d_err_d = !mem_rdy;
                        if (mem_rdy) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                re_d    = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= ARB_OWN_IF;
            streak_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            if_rdy_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_rdy_q    <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            re_q       <= re_d;
            we_q       <= we_d;
            if_rdy_q   <= if_rdy_d;
            if_err_q   <= if_err_d;
            d_rdy_q    <= d_rdy_d;
            d_err_q    <= d_err_d;
        end
    end

    assign if_rdy    = if_rdy_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdy     = d_rdy_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations
// plus a transaction-level reference model compared on every falling edge.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TO   = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_rdy, if_err;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_rdy, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rdy = 1'b0;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdy(if_rdy), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_err(d_err), .d_rdata(d_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=\"%s\" required=\"%s\"", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one access at a time. An access occupies BUSY cycles
    // numbered 1..n, ends on the first cycle with mem_rdy or at cycle TO, and
    // is followed by a single response cycle.
    bit            m_busy = 0, m_resp = 0, m_own_if = 1, m_store = 0, m_err = 0;
    int            m_bcnt = 0, m_streak = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;
    string         m_grants[$];
    string         dut_done[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_resp = 0; m_own_if = 1; m_store = 0; m_err = 0;
            m_bcnt = 0; m_streak = 0;
            m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            m_bcnt = m_bcnt + 1;
            if (mem_rdy) begin
                if (m_own_if) m_if_rdata = mem_rdata; else m_d_rdata = mem_rdata;
                m_err = 0; m_busy = 0; m_resp = 1;
            end else if (m_bcnt == TO) begin
                m_err = 1; m_busy = 0; m_resp = 1;
            end
        end else begin
            if (if_req && (!d_req || m_streak == MAXS)) begin
                m_own_if = 1; m_store = 0; m_addr = if_addr; m_wdata = '0;
                m_streak = 0; m_busy = 1; m_bcnt = 0;
                m_grants.push_back("IF");
            end else if (d_req) begin
                m_own_if = 0; m_store = d_we; m_addr = d_addr; m_wdata = d_wdata;
                m_streak = if_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
                m_busy = 1; m_bcnt = 0;
                m_grants.push_back("D");
            end else begin
                m_streak = 0;
            end
        end
    end

    int n_if_rdy = 0;
    int n_d_rdy  = 0;

    always @(negedge clk) begin
        chk("cmp_mem_re",   mem_re,   m_busy && (m_own_if || !m_store));
        chk("cmp_mem_we",   mem_we,   m_busy && !m_own_if && m_store);
        chk("cmp_strobe_excl", mem_re & mem_we, 1'b0);
        chk("cmp_mem_addr", mem_addr, m_addr);
        chk("cmp_mem_wdata", mem_wdata, m_wdata);
        chk("cmp_if_rdy",   if_rdy,   m_resp && m_own_if);
        chk("cmp_if_err",   if_err,   m_resp && m_own_if && m_err);
        chk("cmp_if_rdata", if_rdata, m_if_rdata);
        chk("cmp_d_rdy",    d_rdy,    m_resp && !m_own_if);
        chk("cmp_d_err",    d_err,    m_resp && !m_own_if && m_err);
        chk("cmp_d_rdata",  d_rdata,  m_d_rdata);
        if (if_rdy) begin n_if_rdy++; dut_done.push_back("IF"); end
        if (d_rdy)  begin n_d_rdy++;  dut_done.push_back("D");  end
    end

    function automatic string join_q(input string q[$]);
        string s = "";
        foreach (q[i]) s = (i == 0) ? q[i] : {s, " ", q[i]};
        return s;
    endfunction

    initial begin
        int base;
        int got;
        int guard;

        // Reset state
        repeat (2) tick();
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdy", if_rdy, 1'b0);
        chk("rst_d_rdy", d_rdy, 1'b0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b1;
        tick();

        // Single fetch, mem_rdy in first BUSY cycle
        if_req = 1'b1; if_addr = 32'h10;
        tick();                                   // cycle 1
        chk("f_mem_re_c1", mem_re, 1'b1);
        chk("f_mem_addr", mem_addr, 32'h10);
        mem_rdy = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();                                   // cycle 2
        mem_rdy = 1'b0; mem_rdata = '0;
        chk("f_mem_re_c2", mem_re, 1'b0);
        chk("f_if_rdy", if_rdy, 1'b1);
        chk("f_if_err", if_err, 1'b0);
        chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        tick();                                   // cycle 3
        chk("f_if_rdy_c3", if_rdy, 1'b0);
        chk("f_if_rdata_hold", if_rdata, 32'hDEADBEEF);

        // Store, mem_rdy in the third BUSY cycle
        tick();
        base = n_d_rdy;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk("st_mem_we", mem_we, 1'b1);
            chk("st_mem_re", mem_re, 1'b0);
            chk("st_mem_addr", mem_addr, 32'h40);
            chk("st_mem_wdata", mem_wdata, 32'h1234);
            if (c == 3) begin mem_rdy = 1'b1; mem_rdata = 32'h5555; end
            tick();
        end
        mem_rdy = 1'b0;
        chk("st_d_rdy", d_rdy, 1'b1);
        chk("st_d_err", d_err, 1'b0);
        chk("st_mem_we_resp", mem_we, 1'b0);
        d_req = 1'b0; d_we = 1'b0;
        tick(); tick();
        chk("st_single_pulse", n_d_rdy - base, 1);

        // Contention: both requests held, memory answers immediately
        m_grants.delete(); dut_done.delete();
        if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
        got = 0; guard = 0;
        while (got < 10 && guard < 200) begin
            tick(); guard++;
            mem_rdy = mem_re | mem_we;
            mem_rdata = 32'hA5A5A5A5;
            if (if_rdy | d_rdy) begin
                got++;
                if (got == 10) begin if_req = 1'b0; d_req = 1'b0; end
            end
        end
        mem_rdy = 1'b0;
        chk("cont_budget", got, 10);
        tick();
        chk_str("cont_dut_order", join_q(dut_done), "D D D D IF D D D D IF");
        chk_str("cont_model_order", join_q(m_grants), "D D D D IF D D D D IF");

        // Timeout on a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        tick();                                   // BUSY cycle 1
        for (int c = 1; c <= TO; c++) begin
            chk("to_mem_re", mem_re, 1'b1);
            tick();
        end                                       // cycle 16
        chk("to_d_rdy", d_rdy, 1'b1);
        chk("to_d_err", d_err, 1'b1);
        chk("to_d_rdata", d_rdata, 32'hA5A5A5A5);
        chk("to_mem_re_resp", mem_re, 1'b0);
        d_req = 1'b0;
        tick();                                   // cycle 17, IDLE
        chk("to_d_rdy_c17", d_rdy, 1'b0);

        // New load sampled at edge 17 proves IDLE; mem_rdy in 15th BUSY cycle
        d_req = 1'b1; d_addr = 32'hC0;
        tick();
        chk("sim_mem_re_c1", mem_re, 1'b1);
        for (int c = 1; c <= TO; c++) begin
            if (c == TO) begin mem_rdy = 1'b1; mem_rdata = 32'hCAFEF00D; end
            tick();
        end
        mem_rdy = 1'b0;
        chk("sim_d_rdy", d_rdy, 1'b1);
        chk("sim_d_err", d_err, 1'b0);
        chk("sim_d_rdata", d_rdata, 32'hCAFEF00D);
        d_req = 1'b0;
        tick();

        // Reset in BUSY
        base = n_if_rdy;
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        chk("rb_mem_re_c1", mem_re, 1'b1);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rb_async_re", mem_re, 1'b0);
        chk("rb_async_we", mem_we, 1'b0);
        if_req = 1'b0;
        tick(); tick();
        chk("rb_no_rdy", n_if_rdy - base, 0);
        rst = 1'b1;
        tick();
        if_req = 1'b1;
        tick();
        chk("rb_reissue_re", mem_re, 1'b1);
        chk("rb_reissue_addr", mem_addr, 32'h300);
        mem_rdy = 1'b1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_rdy = 1'b0;
        chk("rb_if_rdy", if_rdy, 1'b1);
        chk("rb_if_rdata", if_rdata, 32'h0BADF00D);
        if_req = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch path and the load/store data path of the CPU. It sits in front of the `memory` block, owns its `re`/`we`/`address`/`data_w` inputs, and returns `data_r` to the winning requester with a one-cycle ready pulse. It adds a bounded-starvation priority scheme and a watchdog that terminates any access the memory never acknowledges.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MAX_D_STREAK`, 4: consecutive data grants allowed while a fetch waits.
- `TIMEOUT`, 15: BUSY cycles without `mem_rdy` before abort (1..255).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `if_req` input 1: fetch request, held until `if_rdy`.
- `if_addr` input ADDR_W: fetch address, stable while `if_req`.
- `if_rdy` output 1: one-cycle completion pulse to fetch.
- `if_err` output 1: valid with `if_rdy`; access timed out.
- `if_rdata` output DATA_W: fetched word, valid with `if_rdy`.
- `d_req` input 1: data request, held until `d_rdy`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input ADDR_W: data address.
- `d_wdata` input DATA_W: store data.
- `d_rdy` output 1: one-cycle completion pulse to data port.
- `d_err` output 1: valid with `d_rdy`; access timed out.
- `d_rdata` output DATA_W: load data, valid with `d_rdy`.
- `mem_re` output 1: memory read strobe.
- `mem_we` output 1: memory write strobe.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output DATA_W: memory write data.
- `mem_rdata` input DATA_W: memory read data.
- `mem_rdy` input 1: memory completion.

## Operation
- States: IDLE, BUSY, RESP. Reset → IDLE; all outputs 0, streak counter 0, owner = fetch.
- IDLE: requests are sampled only here. Winner selection: data wins by default. If `if_req` is pending and the streak counter equals `MAX_D_STREAK`, fetch wins. On any grant, `mem_addr`/`mem_wdata`/`d_we` are latched into registers and the owner is recorded. Go to BUSY.
- Streak counter: +1 on each data grant while `if_req` is high (saturates at `MAX_D_STREAK`). Cleared on any fetch grant, and cleared in IDLE when `if_req` is low.
- BUSY: `mem_re` = owner is fetch, or owner is data with load; `mem_we` = owner is data with store. Both strobes are driven from registers and never assert together. The watchdog counts BUSY cycles.
  - On `mem_rdy`: capture `mem_rdata` into the owner's rdata register and go to RESP with err=0.
  - When the watchdog reaches `TIMEOUT`: go to RESP with err=1; the rdata register is unchanged.
  - If `mem_rdy` and the timeout occur in the same cycle, `mem_rdy` wins (err=0).
- RESP: strobes are 0. The owner's `*_rdy` is 1 for exactly this cycle, with `*_err`. Next state is IDLE.
- Requester rule: drop `req` in the cycle `rdy` is seen. A `req` still high in the following IDLE cycle is a new request.
- Store completion still returns `d_rdata` = `mem_rdata` captured at `mem_rdy`; software ignores it.
- `*_rdata` holds its value until the next completion for that port.
- Reset mid-access (`rst` low in BUSY or RESP): immediate IDLE, strobes drop asynchronously, and no `rdy` is issued. The requester reissues.

## Timing
- Edge 0 samples a request in IDLE; BUSY starts cycle 1 with strobes high.
- If `mem_rdy` is high in cycle k, RESP occurs in cycle k+1 and IDLE in cycle k+2.
- Minimum round trip: request at cycle 0, `rdy` at cycle 2, next grant sampled at edge 3.
- Timeout abort: `rdy` with err in cycle `TIMEOUT`+1.
- No combinational path from any input to any output.

## Structure
- Shared package `cpu_pkg`:
  - state enum `arb_state_t` {IDLE, BUSY, RESP};
  - owner encoding `ARB_OWN_IF`/`ARB_OWN_D`;
  - default widths.
- Optional sub-module `arb_watchdog`: a loadable down-counter with a `expired` flag. All other logic stays flat.

## Test plan
- Single fetch: `if_req`, `if_addr`=0x10, `mem_rdy` in the 1st BUSY cycle returning 0xDEADBEEF → `mem_re`=1 in cycle 1 only; `if_rdy`=1 in cycle 2 with `if_rdata`=0xDEADBEEF, `if_err`=0.
- Store: `d_req`, `d_we`=1, `d_addr`=0x40, `d_wdata`=0x1234, `mem_rdy` after 3 cycles → `mem_we`=1 for 3 cycles with `mem_addr`=0x40 and `mem_wdata`=0x1234; `mem_re`=0 throughout; single `d_rdy` pulse.
- Contention: `if_req` and `d_req` both held continuously, `mem_rdy` immediate → grant order D,D,D,D,IF,D,D,D,D,IF; no grant overlap.
- Timeout: load request with `mem_rdy` never asserted → `d_rdy`=1, `d_err`=1 in cycle 16; `d_rdata` unchanged; back in IDLE in cycle 17.
- Simultaneous `mem_rdy` and timeout in the 15th BUSY cycle → err=0 and data captured.
- Reset in BUSY: assert `rst`=0 mid-access → `mem_re`/`mem_we` go to 0 without a clock edge; no `rdy` pulse. After release, a new request is served normally.
